// File: rtl/stack_pkg.sv
// Shared op encodings and sizing helpers for the stack unit.
package stack_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [2:0] D_NOP      = 3'd0;
    localparam logic [2:0] D_PUSH     = 3'd1;
    localparam logic [2:0] D_POP      = 3'd2;
    localparam logic [2:0] D_POP2PUSH = 3'd3;
    localparam logic [2:0] D_SWAP     = 3'd4;
    localparam logic [2:0] D_ROT      = 3'd5;
    localparam logic [2:0] D_REPLACE  = 3'd6;

    localparam logic [1:0] R_NOP  = 2'd0;
    localparam logic [1:0] R_PUSH = 2'd1;
    localparam logic [1:0] R_POP  = 2'd2;

    function automatic int depth_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stack_lifo.sv
// Checked LIFO: pointer + storage, top-3 read ports, sticky over/underflow.
module stack_lifo
    import stack_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = 16,
    parameter bit PERM_EN = 1'b1,
    localparam int AW     = depth_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] tos_o,
    output logic [WIDTH-1:0] nos_o,
    output logic [WIDTH-1:0] ros_o,
    output logic [AW-1:0]    depth_o,
    output logic [AW-1:0]    depth_nxt_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [IW-1:0] ip, i1, i2, i3;
    logic has1, has2, has3, full;
    logic do_push, do_p2p, do_swap, do_rot, do_repl;

    assign has1 = depth_q >= AW'(1);
    assign has2 = depth_q >= AW'(2);
    assign has3 = depth_q >= AW'(3);
    assign full = depth_q == AW'(DEPTH);

    // Indices wrap when the entry is absent; every use is guarded.
    assign ip = IW'(depth_q);
    assign i1 = IW'(depth_q - AW'(1));
    assign i2 = IW'(depth_q - AW'(2));
    assign i3 = IW'(depth_q - AW'(3));

    always_comb begin
        do_push = 1'b0;
        do_p2p  = 1'b0;
        do_swap = 1'b0;
        do_rot  = 1'b0;
        do_repl = 1'b0;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (op_i)
            D_PUSH: begin
                if (!full) begin
                    do_push = 1'b1;
                    depth_d = depth_q + AW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            D_POP: begin
                if (has1) depth_d = depth_q - AW'(1);
                else      unf_d = 1'b1;
            end
            D_POP2PUSH: begin
                if (has2) begin
                    do_p2p  = 1'b1;
                    depth_d = depth_q - AW'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
            D_SWAP: begin
                if (PERM_EN) begin
                    if (has2) do_swap = 1'b1;
                    else      unf_d = 1'b1;
                end
            end
            D_ROT: begin
                if (PERM_EN) begin
                    if (has3) do_rot = 1'b1;
                    else      unf_d = 1'b1;
                end
            end
            D_REPLACE: begin
                if (has1) do_repl = 1'b1;
                else      unf_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) mem_q[ip] <= wdata_i;
            if (do_p2p)  mem_q[i2] <= wdata_i;
            if (do_repl) mem_q[i1] <= wdata_i;
            if (do_swap) begin
                mem_q[i1] <= mem_q[i2];
                mem_q[i2] <= mem_q[i1];
            end
            if (do_rot) begin
                mem_q[i1] <= mem_q[i3];
                mem_q[i3] <= mem_q[i2];
                mem_q[i2] <= mem_q[i1];
            end
        end
    end

    assign tos_o       = has1 ? mem_q[i1] : '0;
    assign nos_o       = has2 ? mem_q[i2] : '0;
    assign ros_o       = has3 ? mem_q[i3] : '0;
    assign depth_o     = depth_q;
    assign depth_nxt_o = depth_d;
    assign ovf_o       = ovf_q;
    assign unf_o       = unf_q;

endmodule

// File: rtl/stack_unit.sv
// Data + return stacks for the 16-bit stack core.
// Define STACK_HWM_EN to add high-water-mark outputs d_hwm / r_hwm.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = 16,
    parameter int RDEPTH = 16,
    localparam int DW    = depth_w(DEPTH),
    localparam int RW    = depth_w(RDEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       d_op,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [1:0]       r_op,
    input  logic [WIDTH-1:0] r_wdata,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] ros,
    output logic [WIDTH-1:0] rtos,
    output logic [DW-1:0]    d_depth,
    output logic [RW-1:0]    r_depth,
    output logic             d_ovf,
    output logic             d_unf,
    output logic             r_ovf,
    output logic             r_unf
`ifdef STACK_HWM_EN
    ,
    output logic [DW-1:0]    d_hwm,
    output logic [RW-1:0]    r_hwm
`endif
);

    logic [2:0]       r_lop;
    logic [WIDTH-1:0] r_nos, r_ros;
    logic [DW-1:0]    d_nxt;
    logic [RW-1:0]    r_nxt;
    logic             unused_r;

    always_comb begin
        r_lop = D_NOP;
        unique case (1'b1)
            (r_op == R_PUSH): r_lop = D_PUSH;
            (r_op == R_POP):  r_lop = D_POP;
            default: ;
        endcase
    end

    stack_lifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PERM_EN (1'b1)
    ) u_dstk (
        .clk         (clk),
        .rst         (rst),
        .op_i        (d_op),
        .wdata_i     (d_wdata),
        .tos_o       (tos),
        .nos_o       (nos),
        .ros_o       (ros),
        .depth_o     (d_depth),
        .depth_nxt_o (d_nxt),
        .ovf_o       (d_ovf),
        .unf_o       (d_unf)
    );

    stack_lifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (RDEPTH),
        .PERM_EN (1'b0)
    ) u_rstk (
        .clk         (clk),
        .rst         (rst),
        .op_i        (r_lop),
        .wdata_i     (r_wdata),
        .tos_o       (rtos),
        .nos_o       (r_nos),
        .ros_o       (r_ros),
        .depth_o     (r_depth),
        .depth_nxt_o (r_nxt),
        .ovf_o       (r_ovf),
        .unf_o       (r_unf)
    );

`ifdef STACK_HWM_EN
    logic [DW-1:0] d_hwm_q;
    logic [RW-1:0] r_hwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_hwm_q <= '0;
            r_hwm_q <= '0;
        end else begin
            if (d_nxt > d_hwm_q) d_hwm_q <= d_nxt;
            if (r_nxt > r_hwm_q) r_hwm_q <= r_nxt;
        end
    end

    assign d_hwm    = d_hwm_q;
    assign r_hwm    = r_hwm_q;
    assign unused_r = ^{r_nos, r_ros};
`else
    assign unused_r = ^{r_nos, r_ros, d_nxt, r_nxt};
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed + random bench for stack_unit with a queue-model scoreboard.
module tb_stack_unit;
    import stack_pkg::*;

    localparam int DEPTH  = 16;
    localparam int RDEPTH = 16;

    typedef struct packed {
        logic [15:0] tos, nos, ros, rtos;
        logic [4:0]  dd, rd;
        logic        dovf, dunf, rovf, runf;
        logic [4:0]  dh, rh;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  d_op = D_NOP;
    logic [15:0] d_wdata = '0;
    logic [1:0]  r_op = R_NOP;
    logic [15:0] r_wdata = '0;
    logic [15:0] tos, nos, ros, rtos;
    logic [4:0]  d_depth, r_depth;
    logic        d_ovf, d_unf, r_ovf, r_unf;
`ifdef STACK_HWM_EN
    logic [4:0]  d_hwm, r_hwm;
`endif

    stack_unit #(.WIDTH(16), .DEPTH(DEPTH), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst(rst),
        .d_op(d_op), .d_wdata(d_wdata),
        .r_op(r_op), .r_wdata(r_wdata),
        .tos(tos), .nos(nos), .ros(ros), .rtos(rtos),
        .d_depth(d_depth), .r_depth(r_depth),
        .d_ovf(d_ovf), .d_unf(d_unf), .r_ovf(r_ovf), .r_unf(r_unf)
`ifdef STACK_HWM_EN
        , .d_hwm(d_hwm), .r_hwm(r_hwm)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] dq[$];
    logic [15:0] rq[$];
    logic        m_dovf, m_dunf, m_rovf, m_runf;
    int          m_dh, m_rh;
    snap_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [15:0] mtop(input int k);
        int s = dq.size();
        return (s >= k) ? dq[s-k] : 16'h0;
    endfunction

    function automatic logic [15:0] mrtop();
        return (rq.size() >= 1) ? rq[rq.size()-1] : 16'h0;
    endfunction

    function automatic snap_t snap();
        snap_t s;
        s.tos  = mtop(1);
        s.nos  = mtop(2);
        s.ros  = mtop(3);
        s.rtos = mrtop();
        s.dd   = 5'(dq.size());
        s.rd   = 5'(rq.size());
        s.dovf = m_dovf;
        s.dunf = m_dunf;
        s.rovf = m_rovf;
        s.runf = m_runf;
        s.dh   = 5'(m_dh);
        s.rh   = 5'(m_rh);
        return s;
    endfunction

    task automatic model_reset();
        dq.delete();
        rq.delete();
        m_dovf = 0; m_dunf = 0; m_rovf = 0; m_runf = 0;
        m_dh = 0; m_rh = 0;
    endtask

    task automatic model_apply(input logic [2:0] dop, input logic [15:0] dw,
                               input logic [1:0] rop, input logic [15:0] rw);
        int s = dq.size();
        logic [15:0] a, b, c;
        case (dop)
            D_PUSH: if (s < DEPTH) dq.push_back(dw); else m_dovf = 1;
            D_POP: if (s >= 1) void'(dq.pop_back()); else m_dunf = 1;
            D_POP2PUSH: begin
                if (s >= 2) begin
                    void'(dq.pop_back());
                    void'(dq.pop_back());
                    dq.push_back(dw);
                end else m_dunf = 1;
            end
            D_SWAP: begin
                if (s >= 2) begin
                    a = dq[s-1]; b = dq[s-2];
                    dq[s-1] = b; dq[s-2] = a;
                end else m_dunf = 1;
            end
            D_ROT: begin
                if (s >= 3) begin
                    a = dq[s-1]; b = dq[s-2]; c = dq[s-3];
                    dq[s-1] = c; dq[s-3] = b; dq[s-2] = a;
                end else m_dunf = 1;
            end
            D_REPLACE: if (s >= 1) dq[s-1] = dw; else m_dunf = 1;
            default: ;
        endcase
        case (rop)
            R_PUSH: if (rq.size() < RDEPTH) rq.push_back(rw); else m_rovf = 1;
            R_POP: if (rq.size() >= 1) void'(rq.pop_back()); else m_runf = 1;
            default: ;
        endcase
        if (dq.size() > m_dh) m_dh = dq.size();
        if (rq.size() > m_rh) m_rh = rq.size();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        snap_t e = sb.pop_front();
        chk("tos", 32'(tos), 32'(e.tos));
        chk("nos", 32'(nos), 32'(e.nos));
        chk("ros", 32'(ros), 32'(e.ros));
        chk("rtos", 32'(rtos), 32'(e.rtos));
        chk("d_depth", 32'(d_depth), 32'(e.dd));
        chk("r_depth", 32'(r_depth), 32'(e.rd));
        chk("flags", 32'({d_ovf, d_unf, r_ovf, r_unf}),
            32'({e.dovf, e.dunf, e.rovf, e.runf}));
`ifdef STACK_HWM_EN
        chk("d_hwm", 32'(d_hwm), 32'(e.dh));
        chk("r_hwm", 32'(r_hwm), 32'(e.rh));
`endif
    endtask

    task automatic step(input logic [2:0] dop, input logic [15:0] dw,
                        input logic [1:0] rop, input logic [15:0] rw);
        d_op = dop; d_wdata = dw; r_op = rop; r_wdata = rw;
        model_apply(dop, dw, rop, rw);
        sb.push_back(snap());
        @(posedge clk);
        #1;
        d_op = D_NOP; r_op = R_NOP;
        check_out();
    endtask

    task automatic do_reset(input logic [2:0] dop);
        rst = 1'b1; d_op = dop; d_wdata = 16'h1234;
        r_op = R_PUSH; r_wdata = 16'h4321;
        model_reset();
        sb.push_back(snap());
        @(posedge clk);
        #1;
        rst = 1'b0; d_op = D_NOP; r_op = R_NOP;
        check_out();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset(D_NOP);
        chk("rst_depth", 32'(d_depth), 32'd0);

        step(D_PUSH, 16'd5, R_NOP, 0);
        step(D_PUSH, 16'd7, R_NOP, 0);
        step(D_POP2PUSH, 16'd12, R_NOP, 0);
        chk("p2p_depth", 32'(d_depth), 32'd1);
        chk("p2p_tos", 32'(tos), 32'd12);
        chk("p2p_nos", 32'(nos), 32'd0);
        chk("p2p_flags", 32'({d_ovf, d_unf}), 32'd0);

        do_reset(D_NOP);
        step(D_PUSH, 16'd1, R_NOP, 0);
        step(D_PUSH, 16'd2, R_NOP, 0);
        step(D_PUSH, 16'd3, R_NOP, 0);
        step(D_ROT, 16'd0, R_NOP, 0);
        chk("rot_tos", 32'(tos), 32'd1);
        chk("rot_nos", 32'(nos), 32'd3);
        chk("rot_ros", 32'(ros), 32'd2);
        step(D_SWAP, 16'd0, R_NOP, 0);
        chk("swap_tos", 32'(tos), 32'd3);
        chk("swap_nos", 32'(nos), 32'd1);
        step(D_REPLACE, 16'h0055, R_NOP, 0);
        chk("repl_tos", 32'(tos), 32'h55);
        chk("repl_depth", 32'(d_depth), 32'd3);

        do_reset(D_NOP);
        for (int i = 1; i <= DEPTH + 1; i++) step(D_PUSH, 16'(i), R_NOP, 0);
        chk("full_depth", 32'(d_depth), 32'd16);
        chk("full_tos", 32'(tos), 32'd16);
        chk("full_ovf", 32'(d_ovf), 32'd1);
        step(D_POP, 16'd0, R_NOP, 0);
        chk("pop_tos", 32'(tos), 32'd15);
        chk("ovf_sticky", 32'(d_ovf), 32'd1);

        do_reset(D_NOP);
        step(D_POP, 16'd0, R_NOP, 0);
        chk("unf_pop", 32'(d_unf), 32'd1);
        step(D_PUSH, 16'd9, R_NOP, 0);
        step(D_SWAP, 16'd0, R_NOP, 0);
        chk("unf_swap_depth", 32'(d_depth), 32'd1);
        chk("unf_swap_tos", 32'(tos), 32'd9);
        step(D_PUSH, 16'd8, R_NOP, 0);
        step(D_ROT, 16'd0, R_NOP, 0);
        chk("unf_rot_tos", 32'(tos), 32'd8);
        step(3'd7, 16'hFFFF, 2'd3, 16'hFFFF);

        do_reset(D_NOP);
        step(D_PUSH, 16'h00AA, R_NOP, 0);
        step(D_POP, 16'd0, R_PUSH, mtop(1));
        chk("mv_d_depth", 32'(d_depth), 32'd0);
        chk("mv_r_depth", 32'(r_depth), 32'd1);
        chk("mv_rtos", 32'(rtos), 32'hAA);
        step(D_PUSH, mrtop(), R_POP, 0);
        chk("mv_back_tos", 32'(tos), 32'hAA);
        chk("mv_back_rd", 32'(r_depth), 32'd0);
        step(D_PUSH, 16'h0BB, R_POP, 0);
        chk("r_unf", 32'(r_unf), 32'd1);
        chk("r_unf_dside", 32'(tos), 32'hBB);
        for (int i = 0; i <= RDEPTH; i++) step(D_NOP, 0, R_PUSH, 16'(i + 100));
        chk("r_ovf", 32'(r_ovf), 32'd1);
        chk("r_full_rtos", 32'(rtos), 32'd115);

        do_reset(D_NOP);
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 16'($urandom),
                 2'($urandom_range(0, 3)), 16'($urandom));
            if (i % 75 == 74) do_reset(D_NOP);
        end

        do_reset(D_NOP);
        for (int i = 0; i < 4; i++) step(D_PUSH, 16'(i + 40), R_NOP, 0);
        step(D_POP, 16'd0, R_NOP, 0);
        step(D_POP, 16'd0, R_POP, 0);
`ifdef STACK_HWM_EN
        chk("hwm_peak", 32'(d_hwm), 32'd4);
`endif
        do_reset(D_PUSH);
        chk("mid_rst_depth", 32'({d_depth, r_depth}), 32'd0);
        chk("mid_rst_flags", 32'({d_ovf, d_unf, r_ovf, r_unf}), 32'd0);
`ifdef STACK_HWM_EN
        chk("hwm_rst", 32'(d_hwm), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
